knn_vote: RTL and testbench

- Downstream stage of the KNN core. Consumes the six nearest-neighbour indices (IN1..IN6, nearest first) when the core's valid output pulses.
- Looks up each neighbour's class label in an internal label memory, which the CPU loads beforehand.
- Accumulates a per-class vote histogram, then emits the majority class with its vote count.
- Ties are broken in favour of the class whose first occurrence is nearest.

---
 rtl/knn_vote.sv | 164 ++++++++++++++++
 tb/tb_knn_vote.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// Majority vote over the six nearest neighbours delivered by the KNN core.
// Labels come from a CPU-loaded label memory; ties go to the nearest first occurrence.
module knn_vote #(
    parameter int IDX_W       = 8,
    parameter int NUM_CLASSES = 16,
    parameter int CLASS_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 knn_valid_in,
    input  logic [6*IDX_W-1:0]   in_idx,
    input  logic                 lbl_wr_en,
    input  logic [IDX_W-1:0]     lbl_wr_addr,
    input  logic [CLASS_W-1:0]   lbl_wr_data,
    input  logic                 ovr_clr,
    output logic                 busy,
    output logic                 vote_valid,
    output logic [CLASS_W-1:0]   vote_class,
    output logic [2:0]           vote_count,
    output logic                 overrun
);

    // state  | meaning
    // IDLE   | waiting for knn_valid_in
    // LOOKUP | issuing six label reads, accumulating one cycle behind
    // DRAIN  | accumulating the last returned label
    // SCAN   | walking the histogram one class per cycle
    // DONE   | result presented, vote_valid high
    typedef enum logic [2:0] {IDLE, LOOKUP, DRAIN, SCAN, DONE} state_t;

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    state_t             state;
    logic [CLASS_W-1:0] lbl_mem [2**IDX_W];
    logic [IDX_W-1:0]   cap_idx [6];
    logic [2:0]         rd_ptr;
    logic [IDX_W-1:0]   rd_addr;
    logic [CLASS_W-1:0] rd_lbl;
    logic               acc_vld;
    logic [2:0]         acc_pos;
    logic               lbl_ok;
    logic [2:0]         hist      [2**CLASS_W];
    logic [2:0]         first_pos [2**CLASS_W];
    logic [CLASS_W-1:0] scan_c;
    logic [CLASS_W-1:0] best_class;
    logic [2:0]         best_cnt;
    logic [2:0]         best_pos;
    logic               take;
    logic [CLASS_W-1:0] nxt_class;
    logic [2:0]         nxt_cnt;
    logic [2:0]         nxt_pos;

    assign rd_addr = cap_idx[rd_ptr];
    assign lbl_ok  = {1'b0, rd_lbl} < (CLASS_W+1)'(NUM_CLASSES);

    // Label memory holds its contents through reset; read-first on address collision.
    always_ff @(posedge clk) begin
        if (lbl_wr_en)
            lbl_mem[lbl_wr_addr] <= lbl_wr_data;
        rd_lbl <= lbl_mem[rd_addr];
    end

    always_comb begin
        take = (hist[scan_c] > best_cnt) ||
               ((hist[scan_c] == best_cnt) && (hist[scan_c] != 3'd0) &&
                (first_pos[scan_c] < best_pos));
        nxt_class = best_class;
        nxt_cnt   = best_cnt;
        nxt_pos   = best_pos;
        if (take) begin
            nxt_class = scan_c;
            nxt_cnt   = hist[scan_c];
            nxt_pos   = first_pos[scan_c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            vote_valid <= 1'b0;
            vote_class <= '0;
            vote_count <= 3'd0;
            overrun    <= 1'b0;
            rd_ptr     <= 3'd0;
            acc_vld    <= 1'b0;
            acc_pos    <= 3'd0;
            scan_c     <= '0;
            best_class <= '0;
            best_cnt   <= 3'd0;
            best_pos   <= 3'd0;
            for (int i = 0; i < 6; i++)
                cap_idx[i] <= '0;
            for (int i = 0; i < 2**CLASS_W; i++) begin
                hist[i]      <= 3'd0;
                first_pos[i] <= 3'd0;
            end
        end else begin
            vote_valid <= 1'b0;
            acc_vld    <= 1'b0;

            if (knn_valid_in && state != IDLE)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            if (acc_vld && lbl_ok) begin
                hist[rd_lbl] <= hist[rd_lbl] + 3'd1;
                if (first_pos[rd_lbl] == 3'd7)
                    first_pos[rd_lbl] <= acc_pos;
            end

            case (state)
                IDLE: begin
                    if (knn_valid_in) begin
                        for (int i = 0; i < 6; i++)
                            cap_idx[i] <= in_idx[i*IDX_W +: IDX_W];
                        for (int i = 0; i < 2**CLASS_W; i++) begin
                            hist[i]      <= 3'd0;
                            first_pos[i] <= 3'd7;
                        end
                        rd_ptr <= 3'd0;
                        busy   <= 1'b1;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    acc_vld <= 1'b1;
                    acc_pos <= rd_ptr;
                    if (rd_ptr == 3'd5)
                        state <= DRAIN;
                    else
                        rd_ptr <= rd_ptr + 3'd1;
                end
                DRAIN: begin
                    scan_c     <= '0;
                    best_class <= '0;
                    best_cnt   <= 3'd0;
                    best_pos   <= 3'd7;
                    state      <= SCAN;
                end
                SCAN: begin
                    best_class <= nxt_class;
                    best_cnt   <= nxt_cnt;
                    best_pos   <= nxt_pos;
                    if (scan_c == LAST_CLASS) begin
                        vote_valid <= 1'b1;
                        vote_class <= nxt_class;
                        vote_count <= nxt_cnt;
                        state      <= DONE;
                    end else begin
                        scan_c <= scan_c + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: expected votes are queued at stimulus time
// and compared whenever vote_valid pulses.
module tb_knn_vote;

    localparam int IDX_W       = 8;
    localparam int NUM_CLASSES = 16;
    localparam int CLASS_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 knn_valid_in;
    logic [6*IDX_W-1:0]   in_idx;
    logic                 lbl_wr_en;
    logic [IDX_W-1:0]     lbl_wr_addr;
    logic [CLASS_W-1:0]   lbl_wr_data;
    logic                 ovr_clr;
    logic                 busy;
    logic                 vote_valid;
    logic [CLASS_W-1:0]   vote_class;
    logic [2:0]           vote_count;
    logic                 overrun;

    knn_vote #(.IDX_W(IDX_W), .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .knn_valid_in (knn_valid_in),
        .in_idx       (in_idx),
        .lbl_wr_en    (lbl_wr_en),
        .lbl_wr_addr  (lbl_wr_addr),
        .lbl_wr_data  (lbl_wr_data),
        .ovr_clr      (ovr_clr),
        .busy         (busy),
        .vote_valid   (vote_valid),
        .vote_class   (vote_class),
        .vote_count   (vote_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          votes    = 0;
    logic [6:0]  exp_q [$];
    int          lbls [2**IDX_W];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [6*IDX_W-1:0] mk(input int a, b, c, d, e, f);
        mk = {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: highest count wins; among equals the smallest first position wins.
    function automatic logic [6:0] model(input logic [6*IDX_W-1:0] v);
        int cnt [NUM_CLASSES];
        int fp  [NUM_CLASSES];
        int mx, cls, bp, l;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt[c] = 0;
            fp[c]  = 99;
        end
        for (int p = 0; p < 6; p++) begin
            l = lbls[v[p*IDX_W +: IDX_W]];
            if (l < NUM_CLASSES) begin
                cnt[l]++;
                if (fp[l] == 99) fp[l] = p;
            end
        end
        mx = 0;
        for (int c = 0; c < NUM_CLASSES; c++)
            if (cnt[c] > mx) mx = cnt[c];
        cls = 0;
        bp  = 99;
        if (mx > 0)
            for (int c = 0; c < NUM_CLASSES; c++)
                if (cnt[c] == mx && fp[c] < bp) begin
                    bp  = fp[c];
                    cls = c;
                end
        model = {4'(cls), 3'(mx)};
    endfunction

    task automatic wr_lbl(input int a, input int d);
        @(negedge clk);
        lbl_wr_en   = 1'b1;
        lbl_wr_addr = 8'(a);
        lbl_wr_data = 4'(d);
        lbls[a]     = d;
        @(negedge clk);
        lbl_wr_en   = 1'b0;
    endtask

    // Pulses knn_valid_in for one cycle; returns at the first negedge of cycle T+1.
    task automatic start(input logic [6*IDX_W-1:0] v, input bit push);
        @(negedge clk);
        if (push) exp_q.push_back(model(v));
        in_idx       = v;
        knn_valid_in = 1'b1;
        @(negedge clk);
        knn_valid_in = 1'b0;
    endtask

    task automatic wait_vote(output int n);
        n = 1;
        while (!vote_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("vote_timeout", vote_valid, 1);
    endtask

    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (vote_valid === 1'b1) begin
                votes++;
                check("exp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("vote_class", vote_class, e[6:3]);
                    check("vote_count", vote_count, e[2:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, v0;
        for (int i = 0; i < 2**IDX_W; i++) lbls[i] = 0;
        rst = 1'b1; knn_valid_in = 1'b0; in_idx = '0; lbl_wr_en = 1'b0;
        lbl_wr_addr = '0; lbl_wr_data = '0; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_vote_valid", vote_valid, 0);
        check("rst_vote_class", vote_class, 0);
        check("rst_vote_count", vote_count, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Basic majority and exact latency
        wr_lbl(0, 3); wr_lbl(1, 3); wr_lbl(2, 1); wr_lbl(3, 1); wr_lbl(4, 1); wr_lbl(5, 2);
        start(mk(0, 1, 2, 3, 4, 5), 1);
        check("t1_busy", busy, 1);
        wait_vote(n);
        check("t1_latency", n, 24);
        @(negedge clk);
        check("t1_busy_low", busy, 0);
        check("t1_class_held", vote_class, 1);
        check("t1_count_held", vote_count, 3);

        // Ties resolved by nearest first occurrence
        wr_lbl(10, 2); wr_lbl(11, 5); wr_lbl(12, 5); wr_lbl(13, 2); wr_lbl(14, 7); wr_lbl(15, 7);
        start(mk(10, 11, 12, 13, 14, 15), 1);
        wait_vote(n);
        start(mk(14, 10, 11, 12, 13, 15), 1);
        wait_vote(n);

        // Unanimous votes, including the top class
        wr_lbl(20, 9);
        start(mk(20, 20, 20, 20, 20, 20), 1);
        wait_vote(n);
        wr_lbl(0, 15);
        start(mk(0, 0, 0, 0, 0, 0), 1);
        wait_vote(n);

        // Overrun: second valid at T+5 dropped, clear, re-accept at T+25
        wr_lbl(0, 3);
        start(mk(0, 1, 2, 3, 4, 5), 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        in_idx       = mk(20, 20, 20, 20, 20, 20);
        knn_valid_in = 1'b1;
        @(negedge clk);
        knn_valid_in = 1'b0;
        check("t4_overrun_set", overrun, 1);
        v0 = votes;
        wait_vote(n);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("t4_overrun_clr", overrun, 0);
        check("t4_single_vote", votes - v0, 1);
        exp_q.push_back(model(mk(10, 11, 12, 13, 14, 15)));
        in_idx       = mk(10, 11, 12, 13, 14, 15);
        knn_valid_in = 1'b1;
        @(negedge clk);
        knn_valid_in = 1'b0;
        check("t4_reaccept_busy", busy, 1);
        wait_vote(n);
        check("t4_reaccept_latency", n, 24);

        // Reset mid-vote aborts without a result; labels survive
        start(mk(0, 1, 2, 3, 4, 5), 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        knn_valid_in = 1'b1;
        @(negedge clk);
        knn_valid_in = 1'b0;
        check("t5_overrun_set", overrun, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_overrun", overrun, 0);
        check("t5_vote_class", vote_class, 0);
        check("t5_vote_count", vote_count, 0);
        v0 = votes;
        repeat (30) @(negedge clk);
        check("t5_no_vote", votes - v0, 0);
        start(mk(0, 1, 2, 3, 4, 5), 1);
        wait_vote(n);
        check("t5_latency", n, 24);

        // Write colliding with the first read returns the old label
        wr_lbl(30, 6); wr_lbl(31, 6); wr_lbl(32, 6); wr_lbl(33, 6); wr_lbl(34, 6); wr_lbl(35, 6);
        start(mk(30, 31, 32, 33, 34, 35), 1);
        lbl_wr_en   = 1'b1;
        lbl_wr_addr = 8'd30;
        lbl_wr_data = 4'd4;
        lbls[30]    = 4;
        @(negedge clk);
        lbl_wr_en   = 1'b0;
        wait_vote(n);
        start(mk(30, 30, 30, 30, 30, 30), 1);
        wait_vote(n);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
